// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - multi-cycle unsigned shift-and-add multiply sequencer driving the shared ALU
// Low WIDTH bits of op_a*op_b are produced by alternating ALU add and shift-left-1 steps.
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             mul_ovf_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_sel_o,
  input  logic [WIDTH-1:0] alu_f_i,
  input  logic             alu_ovf_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_DONE
  } state_t;

  localparam logic [2:0]       SEL_ADD  = 3'b000;
  localparam logic [2:0]       SEL_SHL  = 3'b101;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_t             state_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               mul_ovf_q;

  logic [WIDTH-1:0]   q_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               shl_ovf_d;
  logic               last_d;

  // A set multiplicand MSB is lost on the shift only if more multiplier bits remain to use it.
  always_comb begin
    q_d       = q_q >> 1;
    cnt_d     = cnt_q + 1'b1;
    shl_ovf_d = m_q[WIDTH-1] & (|q_d);
    last_d    = (q_d == '0) || (cnt_d == CNT_LAST);
  end

  // ALU is purely combinational: operands are decoded from state and captured in the same cycle.
  always_comb begin
    alu_a_o   = '0;
    alu_b_o   = '0;
    alu_sel_o = SEL_ADD;
    case (state_q)
      S_ADD: begin
        alu_a_o = acc_q;
        alu_b_o = m_q;
      end
      S_SHL: begin
        alu_a_o   = m_q;
        alu_sel_o = SEL_SHL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      mul_ovf_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            m_q    <= op_a_i;
            q_q    <= op_b_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (op_b_i == '0) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              result_q  <= '0;
              mul_ovf_q <= 1'b0;
            end else begin
              state_q <= S_ADD;
            end
          end
        end
        S_ADD: begin
          if (q_q[0]) begin
            acc_q <= alu_f_i;
            ovf_q <= ovf_q | alu_ovf_i;
          end
          state_q <= S_SHL;
        end
        S_SHL: begin
          m_q   <= alu_f_i;
          q_q   <= q_d;
          cnt_q <= cnt_d;
          ovf_q <= ovf_q | shl_ovf_d;
          if (last_d) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            result_q  <= acc_q;
            mul_ovf_q <= ovf_q | shl_ovf_d;
          end else begin
            state_q <= S_ADD;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign mul_ovf_o = mul_ovf_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - directed bench for alu_mul_seq with a behavioural ALU
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        mul_ovf_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [2:0]  alu_sel_o;
  logic [31:0] alu_f;
  logic        alu_ovf;

  int total = 0;
  int bad   = 0;
  int busy_cnt;
  int done_seen;
  logic [2:0] sel_log [0:255];

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .mul_ovf_o (mul_ovf_o),
    .alu_a_o   (alu_a_o),
    .alu_b_o   (alu_b_o),
    .alu_sel_o (alu_sel_o),
    .alu_f_i   (alu_f),
    .alu_ovf_i (alu_ovf)
  );

  // Shared ALU stand-in: add with signed overflow, shift-left-1, anything else is poison.
  always_comb begin
    alu_f   = 32'hDEAD_BEEF;
    alu_ovf = 1'b0;
    case (alu_sel_o)
      3'b000: begin
        alu_f   = alu_a_o + alu_b_o;
        alu_ovf = (alu_a_o[31] == alu_b_o[31]) && (alu_f[31] != alu_a_o[31]);
      end
      3'b101: alu_f = alu_a_o << 1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_res, input logic exp_ovf,
                         input bit poke);
    int n;
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start    = 1'b0;
    n        = 1;
    busy_cnt = 0;
    while (!done_o && n < 200) begin
      sel_log[n] = alu_sel_o;
      if (busy_o) busy_cnt++;
      if (poke && n == 1) begin
        start = 1'b1;
        op_a  = 32'd5;
        op_b  = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy_o) busy_cnt++;
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_res"}, result_o, exp_res);
    chk({tag, "_ovf"}, {31'd0, mul_ovf_o}, {31'd0, exp_ovf});
    @(negedge clk);
    chk({tag, "_done_fall"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_busy_fall"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",    {31'd0, busy_o},    32'd0);
    chk("rst_done",    {31'd0, done_o},    32'd0);
    chk("rst_result",  result_o,           32'd0);
    chk("rst_ovf",     {31'd0, mul_ovf_o}, 32'd0);
    chk("rst_sel",     {29'd0, alu_sel_o}, 32'd0);
    chk("rst_alu_a",   alu_a_o,            32'd0);
    rst = 1'b0;

    // 3*5: three add/shift pairs, so done on cycle 7 and busy through it
    run_mul("m3x5", 32'd3, 32'd5, 7, 32'd15, 1'b0, 1'b0);
    chk("m3x5_busy_cycles", busy_cnt, 32'd7);
    for (int i = 1; i <= 6; i++)
      chk($sformatf("m3x5_sel%0d", i), {29'd0, sel_log[i]},
          (i % 2 == 1) ? 32'h0 : 32'h5);

    run_mul("mb0", 32'd1234, 32'd0, 1, 32'd0, 1'b0, 1'b0);

    // 2^16 * 2^16 wraps to zero; the multiplicand MSB is shifted out while bit 16 of Q remains
    run_mul("m2p16", 32'h0001_0000, 32'h0001_0000, 35, 32'd0, 1'b1, 1'b0);

    run_mul("mffx1", 32'hFFFF_FFFF, 32'd1, 3, 32'hFFFF_FFFF, 1'b0, 1'b1);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_o || busy_o) done_seen++;
    end
    chk("mffx1_no_queue", done_seen, 32'd0);

    // Abandon a long run with reset mid-flight
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'hFF;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 5; i++) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",   {31'd0, busy_o},    32'd0);
    chk("abort_done",   {31'd0, done_o},    32'd0);
    chk("abort_result", result_o,           32'd0);
    chk("abort_ovf",    {31'd0, mul_ovf_o}, 32'd0);
    chk("abort_sel",    {29'd0, alu_sel_o}, 32'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    chk("abort_no_done", done_seen, 32'd0);

    run_mul("m6x7", 32'd6, 32'd7, 7, 32'd42, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
